game_ctrl: RTL and testbench
============================

# game_ctrl

Match sequencer for the pong datapath. It holds the ball in reset during idle and serve intervals, watches ball position to detect misses and update the two scores, and ramps the ball speed with rally length. It declares a winner at a fixed score. It sits between the button debouncers / refresh-tick generator and the ball, score-display and VGA overlay logic.

## Interface
- WIN_SCORE, 7 — points needed to win; must be ≤ 15.
- SERVE_TICKS, 60 — refresh ticks the ball is held at centre before each serve.
- SPEED_MIN, 2 — ball speed at every serve.
- SPEED_MAX, 6 — speed saturation value; must be ≤ 15.
- HITS_PER_STEP, 4 — paddle hits per +1 speed step.
- MISS_L, 16 — ball_x ≤ MISS_L counts as a left miss.
- MISS_R, 624 — ball_x ≥ MISS_R counts as a right miss.
- WRAP_TH, 960 — ball_x ≥ WRAP_TH is an underflowed coordinate and counts as a left miss.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- refresh_tick  in  1  one-cycle frame pulse; the same pulse that drives the ball.
- start  in  1  one-cycle debounced pulse; ignored outside IDLE and OVER.
- ball_x  in  10  current ball x, unsigned.
- ball_dx  in  10  current ball x velocity, two's complement; bit 9 is the direction.
- ball_rst  out  1  registered; holds the ball at centre while high.
- ball_speed  out  4  registered; drives the ball's BALL_SPEED.
- score1, score2  out  4 each  registered; left and right player scores.
- state  out  3  current FSM state encoding.
- winner  out  2  00 none, 01 left player, 10 right player.

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE: ball_rst=1, scores=0, ball_speed=SPEED_MIN, winner=00. start → SERVE.
- SERVE: ball_rst=1. serve_cnt increments on each refresh_tick. When serve_cnt reaches SERVE_TICKS−1 on a tick, go to PLAY and clear serve_cnt. prev_dir is forced to 1 (ball leaves moving left).
- PLAY: ball_rst=0. Evaluated only on refresh_tick:
  - Left miss (ball_x ≤ MISS_L or ball_x ≥ WRAP_TH): score2+1, go to POINT.
  - Right miss (MISS_R ≤ ball_x < WRAP_TH): score1+1, go to POINT.
  - Otherwise, a hit is ball_dx[9] ≠ prev_dir. On a hit, hit_cnt+1; when hit_cnt reaches HITS_PER_STEP it returns to 0 and ball_speed increments, saturating at SPEED_MAX.
  - prev_dir ← ball_dx[9] on every tick.
- POINT (one cycle):
  - If the incremented score equals WIN_SCORE: set winner, go to OVER.
  - Else go to SERVE, with ball_speed←SPEED_MIN, hit_cnt←0, serve_cnt←0.
- OVER: ball_rst=1; scores and winner are frozen. start → SERVE with scores, winner, speed and hit_cnt cleared.
- Priority: a miss overrides a hit on the same tick. Scores never wrap; the game ends first.
- start in SERVE, PLAY or POINT has no effect.

## Timing
- All outputs are registered and change on the clk edge after the qualifying condition.
- Reset values: state=IDLE, ball_rst=1, ball_speed=SPEED_MIN, score1=score2=0, winner=00, serve_cnt=hit_cnt=0, prev_dir=1.
- start in IDLE → state=SERVE one cycle later.
- Serve: ball_rst falls exactly SERVE_TICKS refresh ticks after SERVE entry (on the cycle after the last tick).
- Miss: tick at cycle N → score and state=POINT at N+1 → state=SERVE and ball_rst=1 at N+2.
- reset mid-rally returns to IDLE immediately and asynchronously; all counters clear.

## Structure
- game_pkg holds:
  - the state enum (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4);
  - winner codes;
  - field constants MISS_L, MISS_R, WRAP_TH.
- One sub-module, speed_ramp, owns hit_cnt and ball_speed.
  - Inputs: clk, reset, clear, hit; parameters SPEED_MIN, SPEED_MAX, HITS_PER_STEP.
- The FSM, serve counter, miss detection and scoring live in game_ctrl.

## Test plan
- Reset, then start → state=SERVE; after 60 ticks ball_rst=0 and state=PLAY; ball_speed=2.
- In PLAY, drive ball_x=10 on a tick → score2=1, POINT, then SERVE with ball_rst=1 two cycles after the tick. ball_x=1000 behaves the same; ball_x=630 → score1=1.
- Toggle ball_dx between −2 and +2 on eight ticks → ball_speed=4. Twenty more hits → ball_speed stays 6. The next miss returns ball_speed to 2.
- On one tick, change dx sign and set ball_x=10 together → score2+1, no speed change, state=POINT.
- Score 7 right misses → winner=01, state=OVER, ball_rst=1. start during PLAY is ignored; start in OVER → scores 0, state=SERVE.
- Assert reset mid-PLAY between clock edges → outputs hold reset values immediately, state=IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and playfield constants for the pong match sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package game_pkg;

  // FSM encoding is visible on the state port, so values are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // Playfield x limits; coordinates at or above WRAP_TH are a left-edge underflow.
  localparam logic [9:0] MISS_L  = 10'd16;
  localparam logic [9:0] MISS_R  = 10'd624;
  localparam logic [9:0] WRAP_TH = 10'd960;

endpackage

// File: rtl/game_speed_ramp.sv
// Ball speed ramp: +1 speed every HITS_PER_STEP paddle hits, saturating at SPEED_MAX.
// Latency: ball_speed updates on the clk edge after the qualifying hit/clear.
// Backpressure: none; clear has priority over hit.
module speed_ramp #(
  parameter int SPEED_MIN     = 2,
  parameter int SPEED_MAX     = 6,
  parameter int HITS_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       hit,
  output logic [3:0] ball_speed
);

  localparam logic [3:0] SMIN  = 4'(SPEED_MIN);
  localparam logic [3:0] SMAX  = 4'(SPEED_MAX);
  localparam logic [3:0] HLAST = 4'(HITS_PER_STEP - 1);

  logic [3:0] hit_cnt;

  // Count hits; on the last hit of a step wrap the counter and bump speed unless saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt    <= 4'd0;
      ball_speed <= SMIN;
    end else if (clear) begin
      hit_cnt    <= 4'd0;
      ball_speed <= SMIN;
    end else if (hit) begin
      if (hit_cnt == HLAST) begin
        hit_cnt <= 4'd0;
        if (ball_speed < SMAX) ball_speed <= ball_speed + 4'd1;
      end else begin
        hit_cnt <= hit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Pong match sequencer: serve hold, miss detection, scoring, winner, speed ramp.
// Latency: all outputs registered, one clk after the qualifying condition.
// Backpressure: none; PLAY decisions are taken only on refresh_tick.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_TICKS   = 60,
  parameter int SPEED_MIN     = 2,
  parameter int SPEED_MAX     = 6,
  parameter int HITS_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_dx,
  output logic       ball_rst,
  output logic [3:0] ball_speed,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic [1:0] winner
);

  localparam logic [3:0] WIN_S      = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);

  state_t     st;
  logic [7:0] serve_cnt;
  logic       prev_dir;

  logic left_miss, right_miss, hit, win_l, win_r, ramp_clear;

  // Only the direction bit of the velocity matters here.
  logic unused_dx;
  assign unused_dx = ^ball_dx[8:0];

  assign state      = st;
  assign left_miss  = (ball_x <= MISS_L) || (ball_x >= WRAP_TH);
  assign right_miss = (ball_x >= MISS_R) && (ball_x < WRAP_TH);
  // A miss on the same tick suppresses the hit.
  assign hit        = (st == PLAY) && refresh_tick && !left_miss && !right_miss &&
                      (ball_dx[9] != prev_dir);
  assign win_l      = (score1 == WIN_S);
  assign win_r      = (score2 == WIN_S);
  // Speed is held at its minimum outside rallies, and frozen in OVER until a new game.
  assign ramp_clear = (st == IDLE) || (st == SERVE) ||
                      ((st == POINT) && !win_l && !win_r) ||
                      ((st == OVER) && start);

  speed_ramp #(
    .SPEED_MIN    (SPEED_MIN),
    .SPEED_MAX    (SPEED_MAX),
    .HITS_PER_STEP(HITS_PER_STEP)
  ) u_speed_ramp (
    .clk       (clk),
    .reset     (reset),
    .clear     (ramp_clear),
    .hit       (hit),
    .ball_speed(ball_speed)
  );

  // Match FSM with serve counter, direction history and registered scoring outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      ball_rst  <= 1'b1;
      score1    <= 4'd0;
      score2    <= 4'd0;
      winner    <= WIN_NONE;
      serve_cnt <= 8'd0;
      prev_dir  <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          ball_rst  <= 1'b1;
          score1    <= 4'd0;
          score2    <= 4'd0;
          winner    <= WIN_NONE;
          serve_cnt <= 8'd0;
          prev_dir  <= 1'b1;
          if (start) st <= SERVE;
        end
        SERVE: begin
          ball_rst <= 1'b1;
          prev_dir <= 1'b1;
          if (refresh_tick) begin
            if (serve_cnt == SERVE_LAST) begin
              serve_cnt <= 8'd0;
              ball_rst  <= 1'b0;
              st        <= PLAY;
            end else begin
              serve_cnt <= serve_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          if (refresh_tick) begin
            prev_dir <= ball_dx[9];
            if (left_miss) begin
              score2 <= score2 + 4'd1;
              st     <= POINT;
            end else if (right_miss) begin
              score1 <= score1 + 4'd1;
              st     <= POINT;
            end
          end
        end
        POINT: begin
          ball_rst  <= 1'b1;
          serve_cnt <= 8'd0;
          if (win_l) begin
            winner <= WIN_LEFT;
            st     <= OVER;
          end else if (win_r) begin
            winner <= WIN_RIGHT;
            st     <= OVER;
          end else begin
            st <= SERVE;
          end
        end
        OVER: begin
          ball_rst <= 1'b1;
          if (start) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            winner    <= WIN_NONE;
            serve_cnt <= 8'd0;
            st        <= SERVE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: serve timing, misses, speed ramp, win, async reset.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: none.
module tb_game_ctrl;

  logic       clk;
  logic       reset;
  logic       refresh_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [9:0] ball_dx;
  logic       ball_rst;
  logic [3:0] ball_speed;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [2:0] state;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] DX_NEG = 10'h3FE; // -2
  localparam logic [9:0] DX_POS = 10'h002; // +2

  game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .refresh_tick(refresh_tick),
    .start       (start),
    .ball_x      (ball_x),
    .ball_dx     (ball_dx),
    .ball_rst    (ball_rst),
    .ball_speed  (ball_speed),
    .score1      (score1),
    .score2      (score2),
    .state       (state),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given pulses; returns 1 unit after the rising edge.
  task automatic cyc(input logic t, input logic s);
    refresh_tick = t;
    start        = s;
    @(posedge clk);
    #1;
    refresh_tick = 1'b0;
    start        = 1'b0;
  endtask

  // From SERVE entry: 59 ticks keep the ball held, the 60th releases it.
  task automatic do_serve();
    for (int i = 0; i < 59; i++) cyc(1'b1, 1'b0);
    chk("serve_hold_rst", 32'(ball_rst), 1);
    chk("serve_hold_state", 32'(state), 1);
    cyc(1'b1, 1'b0);
    chk("play_state", 32'(state), 2);
    chk("play_rst", 32'(ball_rst), 0);
  endtask

  initial begin
    reset        = 1'b1;
    refresh_tick = 1'b0;
    start        = 1'b0;
    ball_x       = 10'd320;
    ball_dx      = DX_NEG;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_ball_rst", 32'(ball_rst), 1);
    chk("rst_speed", 32'(ball_speed), 2);
    chk("rst_score1", 32'(score1), 0);
    chk("rst_score2", 32'(score2), 0);
    chk("rst_winner", 32'(winner), 0);
    reset = 1'b0;

    // Start -> SERVE one cycle later, then 60-tick serve.
    cyc(1'b0, 1'b1);
    chk("start_serve", 32'(state), 1);
    do_serve();
    chk("play_speed", 32'(ball_speed), 2);

    // Left miss at x=10.
    ball_x = 10'd10;
    cyc(1'b1, 1'b0);
    chk("lmiss_score2", 32'(score2), 1);
    chk("lmiss_point", 32'(state), 3);
    chk("lmiss_point_rst", 32'(ball_rst), 0);
    ball_x = 10'd320;
    cyc(1'b0, 1'b0);
    chk("lmiss_serve", 32'(state), 1);
    chk("lmiss_serve_rst", 32'(ball_rst), 1);

    // Underflowed coordinate counts as a left miss.
    do_serve();
    ball_x = 10'd1000;
    cyc(1'b1, 1'b0);
    chk("wrap_score2", 32'(score2), 2);
    chk("wrap_point", 32'(state), 3);
    ball_x = 10'd320;
    cyc(1'b0, 1'b0);
    chk("wrap_serve", 32'(state), 1);

    // Right miss.
    do_serve();
    ball_x = 10'd630;
    cyc(1'b1, 1'b0);
    chk("rmiss_score1", 32'(score1), 1);
    chk("rmiss_score2", 32'(score2), 2);
    chk("rmiss_point", 32'(state), 3);
    ball_x = 10'd320;
    cyc(1'b0, 1'b0);

    // Speed ramp: direction flips each tick, ball leaves moving left.
    do_serve();
    cyc(1'b0, 1'b1);
    chk("start_in_play", 32'(state), 2);
    for (int i = 0; i < 4; i++) begin
      ball_dx = (i % 2 == 0) ? DX_POS : DX_NEG;
      cyc(1'b1, 1'b0);
    end
    chk("speed_4hits", 32'(ball_speed), 3);
    for (int i = 4; i < 8; i++) begin
      ball_dx = (i % 2 == 0) ? DX_POS : DX_NEG;
      cyc(1'b1, 1'b0);
    end
    chk("speed_8hits", 32'(ball_speed), 4);
    for (int i = 8; i < 28; i++) begin
      ball_dx = (i % 2 == 0) ? DX_POS : DX_NEG;
      cyc(1'b1, 1'b0);
    end
    chk("speed_sat", 32'(ball_speed), 6);

    // Miss and direction flip on the same tick: miss wins.
    ball_dx = DX_POS;
    ball_x  = 10'd10;
    cyc(1'b1, 1'b0);
    chk("combo_score2", 32'(score2), 3);
    chk("combo_point", 32'(state), 3);
    chk("combo_speed", 32'(ball_speed), 6);
    ball_x  = 10'd320;
    ball_dx = DX_NEG;
    cyc(1'b0, 1'b0);
    chk("combo_serve", 32'(state), 1);
    chk("miss_speed_reset", 32'(ball_speed), 2);

    // Six more right misses take score1 from 1 to 7.
    for (int k = 1; k <= 6; k++) begin
      do_serve();
      ball_x = 10'd630;
      cyc(1'b1, 1'b0);
      chk("win_score1", 32'(score1), 32'(1 + k));
      chk("win_point", 32'(state), 3);
      ball_x = 10'd320;
      cyc(1'b0, 1'b0);
      if (k < 6) chk("win_serve", 32'(state), 1);
    end
    chk("over_state", 32'(state), 4);
    chk("over_winner", 32'(winner), 1);
    chk("over_rst", 32'(ball_rst), 1);

    // OVER freezes scores even on a would-be miss.
    ball_x = 10'd10;
    cyc(1'b1, 1'b0);
    chk("over_frozen_s2", 32'(score2), 3);
    chk("over_frozen_st", 32'(state), 4);
    ball_x = 10'd320;
    cyc(1'b0, 1'b1);
    chk("restart_state", 32'(state), 1);
    chk("restart_s1", 32'(score1), 0);
    chk("restart_s2", 32'(score2), 0);
    chk("restart_winner", 32'(winner), 0);

    // Build some rally state, then reset asynchronously mid-cycle.
    do_serve();
    for (int i = 0; i < 6; i++) begin
      ball_dx = (i % 2 == 0) ? DX_POS : DX_NEG;
      cyc(1'b1, 1'b0);
    end
    chk("pre_reset_speed", 32'(ball_speed), 3);
    ball_x = 10'd10;
    ball_dx = DX_NEG;
    cyc(1'b1, 1'b0);
    ball_x = 10'd320;
    cyc(1'b0, 1'b0);
    do_serve();
    chk("pre_reset_s2", 32'(score2), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_ball_rst", 32'(ball_rst), 1);
    chk("arst_speed", 32'(ball_speed), 2);
    chk("arst_score2", 32'(score2), 0);
    chk("arst_winner", 32'(winner), 0);
    #3 reset = 1'b0;

    // After reset, three hits must not step the speed.
    cyc(1'b0, 1'b1);
    chk("post_reset_serve", 32'(state), 1);
    do_serve();
    for (int i = 0; i < 3; i++) begin
      ball_dx = (i % 2 == 0) ? DX_POS : DX_NEG;
      cyc(1'b1, 1'b0);
    end
    chk("post_reset_speed", 32'(ball_speed), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
